stream_demux_n: RTL and testbench
=================================

# stream_demux_n

Parametrised, registered 1-to-N stream demultiplexer with per-output valid/ready handshake. One input beat is steered to the output chosen by `in_sel`, or copied to every output in broadcast mode. Each output owns a one-entry holding register, so a stalled output back-pressures only beats aimed at it. The block replaces the fixed 4-bit, 4-way combinational demux wherever the consumers apply flow control.

## Interface
- `WIDTH`, 4: data width per beat.
- `N_OUT`, 4: number of outputs; legal range 2..2**`SEL_W`.
- `SEL_W`, 2: width of `in_sel`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `WIDTH`  input beat.
- `in_sel`  in  `SEL_W`  target output index; ignored when `in_bcast`=1.
- `in_bcast`  in  1  1 = copy beat to all N_OUT outputs.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept the beat this cycle (combinational).
- `out_data`  out  `N_OUT*WIDTH`  output i occupies bits [i*WIDTH +: WIDTH].
- `out_valid`  out  `N_OUT`  per-output beat present.
- `out_ready`  in  `N_OUT`  per-output consumer ready.
- `err_sel`  out  1  one-cycle pulse: a beat with `in_sel` >= N_OUT was dropped.
- `drop_cnt`  out  8  saturating count of dropped beats.

## Operation
- Per output i: holding register `hold_v[i]`, `hold_d[i]`. `out_valid[i]` = `hold_v[i]`; `out_data` slice i = `hold_d[i]` when valid, else all zeros.
- Output i is "free" when `hold_v[i]`=0 or `out_ready[i]`=1 in the current cycle.
- `in_ready` (combinational, independent of `in_valid`):
  - `in_bcast`=1: AND of free over all outputs.
  - `in_bcast`=0, `in_sel` < N_OUT: free[`in_sel`].
  - `in_bcast`=0, `in_sel` >= N_OUT: 1 (beat is accepted and discarded).
- Accept = `in_valid` & `in_ready`. On accept: load `in_data` into the target register(s) and set `hold_v`. Unicast writes only output `in_sel`; broadcast writes all outputs in the same edge.
- Drain: if `hold_v[i]` & `out_ready[i]` and no new load into i, clear `hold_v[i]`. Simultaneous drain and load on the same output: the new beat replaces the old one and `hold_v` stays 1, giving full throughput.
- While `hold_v[i]`=1 and `out_ready[i]`=0, `hold_d[i]` and `out_valid[i]` stay stable.
- Invalid select (accept with `in_bcast`=0, `in_sel` >= N_OUT):
  - No holding register changes.
  - `err_sel`=1 for exactly the next cycle.
  - `drop_cnt` increments and saturates at 255; it never wraps.
- Beats are never reordered per output. A broadcast beat never partially issues: either every output loads it or none does.
- Reset (at any time, including mid-stall): all `hold_v`=0, all `out_data`=0, `err_sel`=0, `drop_cnt`=0. Held beats are discarded. During and after reset with no beats held, `in_ready`=1.

## Timing
- Latency: a beat accepted at edge k appears on `out_valid`/`out_data` immediately after edge k, i.e. 1 cycle.
- Throughput: 1 beat per cycle per output while its `out_ready` is held at 1. Broadcast sustains 1 beat per cycle only while all `out_ready` are 1.
- Combinational paths: `out_ready`, `in_sel`, `in_bcast` → `in_ready`. There is no path from `in_valid` to `in_ready`.
- `err_sel` and `drop_cnt` update at the edge that accepts the dropped beat.

## Test plan
- Reset, then a unicast stream with defaults: beats 4'hA→sel 0, 4'h5→sel 2, 4'hF→sel 3, all `out_ready`=1 → each beat appears on its output one cycle after acceptance. Other slices read 0. `in_ready` stays 1 throughout.
- Stall: hold `out_ready[1]`=0 and send 4'h3 then 4'h7 to sel 1 → 4'h3 is held stable and `in_ready`=0 for the second beat. Raise `out_ready[1]` → 4'h3 drains and 4'h7 loads on the same edge. Meanwhile a beat to sel 2 is still accepted.
- Broadcast: send 4'h9 with `in_bcast`=1 and all outputs ready → all four `out_valid` rise together with 4'h9. Repeat with `out_ready[3]`=0 while output 3 is full → `in_ready`=0 and no output loads.
- Invalid select with N_OUT=3, SEL_W=2: send sel=3 three times → `in_ready`=1, `err_sel` pulses each time, `drop_cnt`=3, no `out_valid`. Force 260 drops → `drop_cnt`=255.
- Parameter sweep WIDTH=16, N_OUT=8, SEL_W=3: random sel/bcast/ready for 10k cycles → scoreboard per-output order and data match. No broadcast is partially issued.
- Reset mid-stall: with outputs 0 and 2 full and stalled, assert `rst` for 1 cycle → next cycle all `out_valid`=0, `out_data`=0, `drop_cnt`=0, `in_ready`=1.

Source files
------------

// File: rtl/stream_demux_n_if.sv
// Stream demux bus: one upstream valid/ready port fanned out to N_OUT
// downstream valid/ready ports, plus drop/error status.
interface stream_demux_n_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SEL_W = 2
);
   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic                   in_bcast;
   logic                   in_valid;
   logic                   in_ready;
   logic [N_OUT*WIDTH-1:0] out_data;
   logic [N_OUT-1:0]       out_valid;
   logic [N_OUT-1:0]       out_ready;
   logic                   err_sel;
   logic [7:0]             drop_cnt;

   // Producer / consumer side, i.e. whatever surrounds the demux.
   modport master (
      output in_data,
      output in_sel,
      output in_bcast,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  err_sel,
      input  drop_cnt
   );

   // The demux itself.
   modport slave (
      input  in_data,
      input  in_sel,
      input  in_bcast,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready,
      output err_sel,
      output drop_cnt
   );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer. Each output has a one-entry
// holding register so a stalled consumer only blocks beats aimed at it.
// Broadcast beats load every output on the same edge or none at all.
// Beats with an out-of-range select are accepted, discarded and counted.
module stream_demux_n #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SEL_W = 2
) (
   input logic             clk,
   input logic             rst,
   stream_demux_n_if.slave bus
);

   logic [N_OUT-1:0] hold_v_q, hold_v_d;
   logic [WIDTH-1:0] hold_d_q [N_OUT];
   logic [WIDTH-1:0] hold_d_d [N_OUT];

   logic [N_OUT-1:0] free;
   logic [N_OUT-1:0] hit;
   logic [N_OUT-1:0] load;
   logic             sel_ok;
   logic             sel_free;
   logic             ready;
   logic             accept;
   logic             drop;

   logic             err_q, err_d;
   logic [7:0]       drop_q, drop_d;

   // One-hot decode of in_sel; sel_ok is clear when in_sel names no output.
   always_comb begin
      hit    = '0;
      sel_ok = 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (32'(bus.in_sel) == i) begin
            hit[i] = 1'b1;
            sel_ok = 1'b1;
         end
      end
   end

   // Acceptance: in_valid never feeds in_ready, only select/bcast/out_ready.
   always_comb begin
      free     = ~hold_v_q | bus.out_ready;
      sel_free = |(free & hit);
      if (bus.in_bcast) begin
         ready = &free;
      end else if (sel_ok) begin
         ready = sel_free;
      end else begin
         // Out-of-range select is always taken so it can be dropped.
         ready = 1'b1;
      end
      accept = bus.in_valid & ready;
      drop   = accept & ~bus.in_bcast & ~sel_ok;
   end

   // Holding-register next state; a load wins over a same-cycle drain.
   always_comb begin
      load = '0;
      if (accept) begin
         load = bus.in_bcast ? {N_OUT{1'b1}} : hit;
      end
      hold_v_d = load | (hold_v_q & ~bus.out_ready);
      for (int unsigned i = 0; i < N_OUT; i++) begin
         hold_d_d[i] = load[i] ? bus.in_data : hold_d_q[i];
      end
   end

   // Drop bookkeeping: one-cycle error pulse and a saturating counter.
   always_comb begin
      err_d  = drop;
      drop_d = drop_q;
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v_q <= '0;
         for (int unsigned i = 0; i < N_OUT; i++) begin
            hold_d_q[i] <= '0;
         end
         err_q  <= 1'b0;
         drop_q <= 8'd0;
      end else begin
         hold_v_q <= hold_v_d;
         for (int unsigned i = 0; i < N_OUT; i++) begin
            hold_d_q[i] <= hold_d_d[i];
         end
         err_q  <= err_d;
         drop_q <= drop_d;
      end
   end

   // Output drive; empty slots read as zero rather than stale data.
   always_comb begin
      bus.out_data = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (hold_v_q[i]) begin
            bus.out_data[i*WIDTH +: WIDTH] = hold_d_q[i];
         end
      end
      bus.out_valid = hold_v_q;
      bus.in_ready  = ready;
      bus.err_sel   = err_q;
      bus.drop_cnt  = drop_q;
   end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: instance A uses the default 4-bit/4-way shape,
// instance B a 16-bit/6-way shape with a 3-bit select so selects 6 and 7
// are out of range. Both are compared every cycle against an occupancy
// model built from the handshake rules.
module tb_stream_demux_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_demux_n_if #(.WIDTH(4),  .N_OUT(4), .SEL_W(2)) ia ();
   stream_demux_n_if #(.WIDTH(16), .N_OUT(6), .SEL_W(3)) ib ();

   stream_demux_n #(.WIDTH(4), .N_OUT(4), .SEL_W(2)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   stream_demux_n #(.WIDTH(16), .N_OUT(6), .SEL_W(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   // Stimulus, index 0 = instance A, 1 = instance B.
   logic [15:0] s_data  [2];
   logic [2:0]  s_sel   [2];
   logic        s_bcast [2];
   logic        s_valid [2];
   logic [7:0]  s_rdy   [2];

   assign ia.in_data   = s_data[0][3:0];
   assign ia.in_sel    = s_sel[0][1:0];
   assign ia.in_bcast  = s_bcast[0];
   assign ia.in_valid  = s_valid[0];
   assign ia.out_ready = s_rdy[0][3:0];
   assign ib.in_data   = s_data[1];
   assign ib.in_sel    = s_sel[1];
   assign ib.in_bcast  = s_bcast[1];
   assign ib.in_valid  = s_valid[1];
   assign ib.out_ready = s_rdy[1][5:0];

   // Observations normalised to common widths.
   logic         o_ready [2];
   logic [7:0]   o_valid [2];
   logic [127:0] o_data  [2];
   logic         o_err   [2];
   logic [7:0]   o_drop  [2];

   assign o_ready[0] = ia.in_ready;
   assign o_valid[0] = {4'b0, ia.out_valid};
   assign o_data[0]  = {112'b0, ia.out_data};
   assign o_err[0]   = ia.err_sel;
   assign o_drop[0]  = ia.drop_cnt;
   assign o_ready[1] = ib.in_ready;
   assign o_valid[1] = {2'b0, ib.out_valid};
   assign o_data[1]  = {32'b0, ib.out_data};
   assign o_err[1]   = ib.err_sel;
   assign o_drop[1]  = ib.drop_cnt;

   // Reference model: per-output occupancy (0 or 1 beat) and the beat held.
   int          occ   [2][8];
   logic [15:0] beat  [2][8];
   bit          m_err [2];
   int          m_drop[2];
   int          n_occ [2][8];
   logic [15:0] n_beat[2][8];
   bit          n_err [2];
   int          n_drop[2];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic int wof(int k);
      return (k == 0) ? 4 : 16;
   endfunction

   function automatic int nof(int k);
      return (k == 0) ? 4 : 6;
   endfunction

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            occ[k][i]  = 0;
            beat[k][i] = '0;
         end
         m_err[k]  = 0;
         m_drop[k] = 0;
      end
   endtask

   // One clock: compare at the falling edge, advance the model over the
   // rising edge, return 1 time unit after it.
   task automatic step();
      string        nm;
      int           n, w, sel;
      bit           rdy, acc, dropped;
      bit           fr [8];
      logic [15:0]  dm;
      logic [7:0]   ev;
      logic [127:0] ed;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         nm  = (k == 0) ? "A" : "B";
         n   = nof(k);
         w   = wof(k);
         sel = int'(s_sel[k]);
         dm  = 16'((32'd1 << w) - 1);
         for (int i = 0; i < 8; i++) fr[i] = (occ[k][i] == 0) || s_rdy[k][i];
         rdy = 1;
         if (s_bcast[k]) begin
            for (int i = 0; i < n; i++) rdy = rdy & fr[i];
         end else if (sel < n) begin
            rdy = fr[sel];
         end
         ev = '0;
         ed = '0;
         for (int i = 0; i < n; i++) begin
            if (occ[k][i] != 0) begin
               ev[i] = 1'b1;
               ed    = ed | (128'(beat[k][i] & dm) << (i * w));
            end
         end
         check($sformatf("%s_in_ready", nm), 128'(o_ready[k]), 128'(rdy));
         check($sformatf("%s_out_valid", nm), 128'(o_valid[k]), 128'(ev));
         check($sformatf("%s_out_data", nm), o_data[k], ed);
         check($sformatf("%s_err_sel", nm), 128'(o_err[k]), 128'(m_err[k]));
         check($sformatf("%s_drop_cnt", nm), 128'(o_drop[k]), 128'(m_drop[k]));

         acc     = s_valid[k] && rdy;
         dropped = acc && !s_bcast[k] && (sel >= n);
         for (int i = 0; i < 8; i++) begin
            n_occ[k][i]  = occ[k][i];
            n_beat[k][i] = beat[k][i];
         end
         for (int i = 0; i < n; i++) begin
            if (occ[k][i] != 0 && s_rdy[k][i]) n_occ[k][i] = 0;
            if (acc && (s_bcast[k] || sel == i)) begin
               n_occ[k][i]  = 1;
               n_beat[k][i] = s_data[k] & dm;
            end
         end
         n_err[k]  = dropped;
         n_drop[k] = dropped ? ((m_drop[k] + 1 > 255) ? 255 : m_drop[k] + 1) : m_drop[k];
         if (rst) begin
            for (int i = 0; i < 8; i++) begin
               n_occ[k][i]  = 0;
               n_beat[k][i] = '0;
            end
            n_err[k]  = 0;
            n_drop[k] = 0;
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            occ[k][i]  = n_occ[k][i];
            beat[k][i] = n_beat[k][i];
         end
         m_err[k]  = n_err[k];
         m_drop[k] = n_drop[k];
      end
   endtask

   task automatic send(int k, logic [15:0] d, logic [2:0] sel, logic bc);
      s_valid[k] = 1'b1;
      s_data[k]  = d;
      s_sel[k]   = sel;
      s_bcast[k] = bc;
      step();
      s_valid[k] = 1'b0;
      s_bcast[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         s_data[k]  = '0;
         s_sel[k]   = '0;
         s_bcast[k] = 1'b0;
         s_valid[k] = 1'b0;
         s_rdy[k]   = 8'hFF;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      step();
      check("reset_out_valid", 128'(ia.out_valid), 128'(0));
      check("reset_in_ready", 128'(ia.in_ready), 128'(1));
      rst = 1'b0;

      // Unicast stream, all consumers ready.
      send(0, 16'hA, 3'd0, 1'b0);
      check("uni_a_data", 128'(ia.out_data), 128'(16'h000A));
      check("uni_a_valid", 128'(ia.out_valid), 128'(4'b0001));
      send(0, 16'h5, 3'd2, 1'b0);
      check("uni_5_data", 128'(ia.out_data), 128'(16'h0500));
      send(0, 16'hF, 3'd3, 1'b0);
      check("uni_f_data", 128'(ia.out_data), 128'(16'hF000));
      step();

      // Stall output 1.
      s_rdy[0] = 8'hFD;
      send(0, 16'h3, 3'd1, 1'b0);
      s_valid[0] = 1'b1; s_data[0] = 16'h7; s_sel[0] = 3'd1;
      #1;
      check("stall_in_ready", 128'(ia.in_ready), 128'(0));
      step();
      check("stall_hold", 128'(ia.out_data[7:4]), 128'(4'h3));
      s_valid[0] = 1'b0;
      send(0, 16'h9, 3'd2, 1'b0);
      check("stall_other", 128'(ia.out_data), 128'(16'h0930));
      s_rdy[0] = 8'hFF;
      send(0, 16'h7, 3'd1, 1'b0);
      check("stall_replace", 128'(ia.out_data), 128'(16'h0070));
      step();

      // Broadcast, then a blocked broadcast.
      send(0, 16'h9, 3'd0, 1'b1);
      check("bcast_valid", 128'(ia.out_valid), 128'(4'b1111));
      check("bcast_data", 128'(ia.out_data), 128'(16'h9999));
      s_rdy[0] = 8'hF7;
      s_valid[0] = 1'b1; s_bcast[0] = 1'b1; s_data[0] = 16'h6;
      #1;
      check("bcast_blocked", 128'(ia.in_ready), 128'(0));
      step();
      s_valid[0] = 1'b0; s_bcast[0] = 1'b0;
      check("bcast_none", 128'(ia.out_data), 128'(16'h9000));
      s_rdy[0] = 8'hFF;
      step();

      // Out-of-range selects on B, then saturation.
      for (int j = 0; j < 3; j++) begin
         send(1, 16'hBEEF, 3'd7, 1'b0);
         check("drop_err", 128'(ib.err_sel), 128'(1));
      end
      check("drop_cnt3", 128'(ib.drop_cnt), 128'(3));
      check("drop_novalid", 128'(ib.out_valid), 128'(0));
      s_valid[1] = 1'b1; s_sel[1] = 3'd6;
      repeat (260) step();
      s_valid[1] = 1'b0;
      check("drop_sat", 128'(ib.drop_cnt), 128'(255));

      // Reset while outputs 0 and 2 are full and stalled.
      s_rdy[0] = 8'h00;
      send(0, 16'h1, 3'd0, 1'b0);
      send(0, 16'h2, 3'd2, 1'b0);
      check("pre_rst_valid", 128'(ia.out_valid), 128'(4'b0101));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_valid", 128'(ia.out_valid), 128'(0));
      check("rst_data", 128'(ia.out_data), 128'(0));
      check("rst_drop", 128'(ib.drop_cnt), 128'(0));
      check("rst_in_ready", 128'(ia.in_ready), 128'(1));
      s_rdy[0] = 8'hFF;

      // Randomised traffic on both instances.
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            s_valid[k] = ($urandom_range(0, 3) != 0);
            s_bcast[k] = ($urandom_range(0, 7) == 0);
            s_sel[k]   = 3'($urandom_range(0, (k == 0) ? 3 : 7));
            s_data[k]  = 16'($urandom);
            for (int i = 0; i < 8; i++) s_rdy[k][i] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
